dense_argmax_layer_2: RTL and testbench

//  Output stage fed by the first dense layer: captures the 32-bit ReLU vector, requantises it to 16 bits,

---
 rtl/dense_argmax_layer_2_pkg.sv | 55 +++++
 rtl/dense_argmax_layer_2_argmax_seq.sv | 68 ++++++
 rtl/dense_argmax_layer_2.sv | 142 ++++++++++++++
 tb/tb_dense_argmax_layer_2.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_argmax_layer_2_pkg.sv
// Shared constants, state type and arithmetic helpers for the second dense layer and its argmax.
// Default weights and biases are deterministic patterns; instances override them via parameters.
package dense_argmax_layer_2_pkg;

  localparam int unsigned OUT_SIZE_1  = 64;
  localparam int unsigned OUT_SIZE_2  = 10;
  localparam int unsigned REQ_SHIFT_2 = 8;

  typedef enum logic [1:0] {StIdle, StMac, StArgmax, StDone} l2_state_t;

  // Weight w[i][j] lives at bits [(i*OUT_SIZE_2+j)*16 +: 16].
  function automatic logic [OUT_SIZE_1*OUT_SIZE_2*16-1:0] gen_weights_2();
    logic [OUT_SIZE_1*OUT_SIZE_2*16-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < int'(OUT_SIZE_1); i++) begin
      for (int j = 0; j < int'(OUT_SIZE_2); j++) begin
        v = ((i * 7 + j * 13) % 61) - 30;
        r[(i*int'(OUT_SIZE_2)+j)*16 +: 16] = 16'(v);
      end
    end
    return r;
  endfunction

  function automatic logic [OUT_SIZE_2*16-1:0] gen_bias_2();
    logic [OUT_SIZE_2*16-1:0] r;
    int v;
    r = '0;
    for (int j = 0; j < int'(OUT_SIZE_2); j++) begin
      v = ((j * 37) % 41) - 20;
      r[j*16 +: 16] = 16'(v);
    end
    return r;
  endfunction

  localparam logic [OUT_SIZE_1*OUT_SIZE_2*16-1:0] WEIGHTS_2 = gen_weights_2();
  localparam logic [OUT_SIZE_2*16-1:0]            BIAS_2    = gen_bias_2();

  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sd2147483647) return 32'sh7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'sh8000_0000;
    return v[31:0];
  endfunction

  // Arithmetic shift, then clamp into the non-negative 15-bit range.
  function automatic logic [15:0] requant16(input logic signed [31:0] v,
                                            input int unsigned shift);
    logic signed [31:0] s;
    s = v >>> shift;
    if (s < 0) return 16'd0;
    if (s > 32'sd32767) return 16'h7FFF;
    return s[15:0];
  endfunction

endpackage

// File: rtl/dense_argmax_layer_2_argmax_seq.sv
// Serial argmax: one score per cycle after start; strict greater-than keeps the lowest index on ties.
module dense_argmax_layer_2_argmax_seq #(
  parameter int unsigned N  = 10,
  parameter int unsigned CW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [N*32-1:0] scores_i,
  output logic            done_o,
  output logic [CW-1:0]   class_o,
  output logic [31:0]     score_o
);

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CW-1:0]      j_q, j_d;
  logic [CW-1:0]      cls_q, cls_d;
  logic signed [31:0] best_q, best_d;
  logic signed [31:0] cur;
  logic               take;

  always_comb begin
    cur    = scores_i[32'(j_q)*32 +: 32];
    take   = (j_q == '0) || (cur > best_q);
    busy_d = busy_q;
    done_d = 1'b0;
    j_d    = j_q;
    cls_d  = cls_q;
    best_d = best_q;
    if (start_i) begin
      busy_d = 1'b1;
      j_d    = '0;
    end else if (busy_q) begin
      if (take) begin
        best_d = cur;
        cls_d  = j_q;
      end
      if (j_q == CW'(N - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      j_q    <= '0;
      cls_q  <= '0;
      best_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      j_q    <= j_d;
      cls_q  <= cls_d;
      best_q <= best_d;
    end
  end

  assign done_o  = done_q;
  assign class_o = cls_q;
  assign score_o = best_q;

endmodule

// File: rtl/dense_argmax_layer_2.sv
// Output stage: requantise the layer-1 vector, run a serial-input dense layer with all outputs
// in parallel, then pick the winning class and offer it on a valid/ready handshake.
module dense_argmax_layer_2
  import dense_argmax_layer_2_pkg::*;
#(
  parameter int unsigned IN_SIZE   = OUT_SIZE_1,
  parameter int unsigned OUT_SIZE  = OUT_SIZE_2,
  parameter int unsigned REQ_SHIFT = REQ_SHIFT_2,
  parameter int unsigned ACC_W     = 40,
  parameter logic [IN_SIZE*OUT_SIZE*16-1:0] WEIGHTS = WEIGHTS_2,
  parameter logic [OUT_SIZE*16-1:0]         BIAS    = BIAS_2,
  localparam int unsigned CW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [IN_SIZE*32-1:0] in_vector_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CW-1:0]         out_class_o,
  output logic [31:0]           out_score_o
);

  localparam int unsigned IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  l2_state_t state_q, state_d;

  logic [IW-1:0]            idx_q, idx_d;
  logic [15:0]              x_q   [IN_SIZE];
  logic [15:0]              x_d   [IN_SIZE];
  logic signed [ACC_W-1:0]  acc_q [OUT_SIZE];
  logic signed [ACC_W-1:0]  acc_d [OUT_SIZE];
  logic [CW-1:0]            class_q, class_d;
  logic [31:0]              score_q, score_d;

  logic                     last_mac;
  logic [OUT_SIZE*32-1:0]   am_scores;
  logic                     am_done;
  logic [CW-1:0]            am_class;
  logic [31:0]              am_score;
  logic [15:0]              w;
  logic signed [31:0]       prod;

  assign last_mac = (state_q == StMac) && (idx_q == IW'(IN_SIZE - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid_i)  state_d = StMac;
      StMac:    if (last_mac)    state_d = StArgmax;
      StArgmax: if (am_done)     state_d = StDone;
      StDone:   if (out_ready_i) state_d = StIdle;
      default:                   state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StDone);
  end

  assign out_class_o = class_q;
  assign out_score_o = score_q;

  always_comb begin
    x_d     = x_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    class_d = class_q;
    score_d = score_q;
    w       = '0;
    prod    = '0;
    if (state_q == StIdle && in_valid_i) begin
      for (int i = 0; i < int'(IN_SIZE); i++) begin
        x_d[i] = requant16(in_vector_i[i*32 +: 32], REQ_SHIFT);
      end
      for (int j = 0; j < int'(OUT_SIZE); j++) begin
        acc_d[j] = {{(ACC_W-16){BIAS[j*16+15]}}, BIAS[j*16 +: 16]};
      end
      idx_d = '0;
    end
    if (state_q == StMac) begin
      // x is always non-negative, so the zero-extended operand keeps the product 16u x 16s.
      for (int j = 0; j < int'(OUT_SIZE); j++) begin
        w        = WEIGHTS[(32'(idx_q)*OUT_SIZE + 32'(j))*16 +: 16];
        prod     = $signed({16'd0, x_q[idx_q]}) * $signed({{16{w[15]}}, w});
        acc_d[j] = acc_q[j] + {{(ACC_W-32){prod[31]}}, prod};
      end
      idx_d = idx_q + 1'b1;
    end
    if (state_q == StArgmax && am_done) begin
      class_d = am_class;
      score_d = am_score;
    end
  end

  always_comb begin
    am_scores = '0;
    for (int j = 0; j < int'(OUT_SIZE); j++) begin
      am_scores[j*32 +: 32] = sat32({{(64-ACC_W){acc_q[j][ACC_W-1]}}, acc_q[j]});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      class_q <= '0;
      score_q <= '0;
      for (int i = 0; i < int'(IN_SIZE); i++) x_q[i] <= '0;
      for (int j = 0; j < int'(OUT_SIZE); j++) acc_q[j] <= '0;
    end else begin
      idx_q   <= idx_d;
      class_q <= class_d;
      score_q <= score_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
    end
  end

  dense_argmax_layer_2_argmax_seq #(
    .N  (OUT_SIZE),
    .CW (CW)
  ) u_argmax (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (last_mac),
    .scores_i (am_scores),
    .done_o   (am_done),
    .class_o  (am_class),
    .score_o  (am_score)
  );

endmodule

// File: tb/tb_dense_argmax_layer_2.sv
// Bench for dense_argmax_layer_2 with a 4-input, 3-class configuration and an arithmetic model.
module tb_dense_argmax_layer_2;

  localparam int IN  = 4;
  localparam int OUT = 3;
  localparam logic [47:0]           ROW = {16'hFFFF, 16'h0002, 16'h0001};
  localparam logic [IN*OUT*16-1:0]  W_P = {ROW, ROW, ROW, ROW};
  localparam logic [OUT*16-1:0]     B_P = {16'hFFFB, 16'h0000, 16'h000A};

  int bias_m [OUT] = '{10, 0, -5};
  int wcol_m [OUT] = '{1, 2, -1};

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b1;
  logic            in_valid  = 1'b0;
  logic            out_ready = 1'b0;
  logic [IN*32-1:0] in_vector = '0;
  logic            in_ready;
  logic            out_valid;
  logic [1:0]      out_class;
  logic [31:0]     out_score;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dense_argmax_layer_2 #(
    .IN_SIZE   (IN),
    .OUT_SIZE  (OUT),
    .REQ_SHIFT (8),
    .ACC_W     (40),
    .WEIGHTS   (W_P),
    .BIAS      (B_P)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_vector_i (in_vector),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_class_o (out_class),
    .out_score_o (out_score)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [IN*32-1:0] v, output int cls, output longint score);
    longint x [IN];
    longint acc, s, best;
    best = 0;
    cls  = 0;
    for (int i = 0; i < IN; i++) begin
      x[i] = longint'($signed(v[i*32 +: 32])) >>> 8;
      if (x[i] < 0) x[i] = 0;
      if (x[i] > 32767) x[i] = 32767;
    end
    for (int j = 0; j < OUT; j++) begin
      acc = bias_m[j];
      for (int i = 0; i < IN; i++) acc += x[i] * wcol_m[j];
      s = acc;
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      if (j == 0 || s > best) begin
        best = s;
        cls  = j;
      end
    end
    score = best;
  endfunction

  function automatic logic [IN*32-1:0] rand_vec();
    logic [IN*32-1:0] v;
    for (int i = 0; i < IN; i++) v[i*32 +: 32] = $signed($urandom) >>> $urandom_range(0, 22);
    return v;
  endfunction

  // Returns one clock edge after the handshake edge (+1 time unit).
  task automatic send(input logic [IN*32-1:0] v);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_vector = v;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [IN*32-1:0] v);
    int     cls;
    longint sc;
    int     lat = 0;
    model(v, cls, sc);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_latency"}, lat, IN + OUT + 1);
    chk({tag, "_class"}, out_class, cls);
    chk({tag, "_score"}, $signed(out_score), sc);
  endtask

  task automatic accept(input string tag);
    logic [1:0]  c;
    logic [31:0] s;
    c = out_class;
    s = out_score;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    chk({tag, "_class_held"}, out_class, c);
    chk({tag, "_score_held"}, out_score, s);
  endtask

  initial begin
    logic [IN*32-1:0] v2, va, vb, v;
    logic [IN*32-1:0] vecs [3];
    int     ecls [3];
    longint esc  [3];
    int     seen, bad, t, nres, nsent, tprev;
    logic [1:0]  c0;
    logic [31:0] s0;

    #2 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_score", out_score, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort mid-MAC
    v2 = {32'd1024, 32'd768, 32'd512, 32'd256};
    send(v2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (14) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    // Tie between classes 0 and 1
    send(v2);
    expect_result("tie", v2);
    chk("tie_class_fixed", out_class, 0);
    chk("tie_score_fixed", out_score, 20);
    accept("tie");

    // Negative inputs requantise to zero: result is the bias argmax
    for (int i = 0; i < IN; i++) v[i*32 +: 32] = -32'sd300;
    send(v);
    expect_result("neg", v);
    chk("neg_score_fixed", out_score, 10);
    accept("neg");

    // Clamp at 32767
    for (int i = 0; i < IN; i++) v[i*32 +: 32] = 32'h7FFF_FFFF;
    send(v);
    expect_result("clamp", v);
    chk("clamp_class_fixed", out_class, 1);
    accept("clamp");

    repeat (6) begin
      v = rand_vec();
      send(v);
      expect_result("rand", v);
      accept("rand");
    end

    // Consumer stalls while a second vector is offered
    va = rand_vec();
    vb = rand_vec();
    send(va);
    expect_result("hold", va);
    in_vector = vb;
    in_valid  = 1'b1;
    c0 = out_class;
    s0 = out_score;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_class !== c0 || out_score !== s0) bad++;
    end
    chk("hold_stable", bad, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("hold_released", out_valid, 0);
    chk("hold_idle", in_ready, 1);
    @(posedge clk);
    #1;
    chk("hold_second_taken", in_ready, 0);
    in_valid = 1'b0;
    expect_result("hold_second", vb);
    accept("hold_second");

    // Back-to-back with both handshakes held open
    for (int k = 0; k < 3; k++) begin
      vecs[k] = rand_vec();
      model(vecs[k], ecls[k], esc[k]);
    end
    t = 0; nres = 0; nsent = 0; tprev = 0;
    in_vector = vecs[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (nres < 3 && t < 200) begin
      @(negedge clk);
      t++;
      if (out_valid) begin
        chk("b2b_class", out_class, ecls[nres]);
        chk("b2b_score", $signed(out_score), esc[nres]);
        if (nres > 0) chk("b2b_spacing", t - tprev, IN + OUT + 3);
        tprev = t;
        nres++;
      end
      if (in_ready && in_valid) begin
        nsent++;
        @(posedge clk);
        #1;
        if (nsent < 3) in_vector = vecs[nsent];
        else in_valid = 1'b0;
      end
    end
    chk("b2b_count", nres, 3);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
